// File: rtl/trig_capture_sampler_if.sv
// trig_capture_sampler_if: sample stream, trigger setup, frame readback and status bundle
interface trig_capture_sampler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_LEN = 1920,
  parameter int NUM_CH = 2
);
  localparam int AW = $clog2(BUF_LEN);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic [NUM_CH*DATA_WIDTH-1:0] din;
  logic din_valid;
  logic arm;
  logic [1:0] trig_mode;
  logic [CW-1:0] trig_ch;
  logic [DATA_WIDTH-1:0] trig_level;
  logic [DATA_WIDTH-1:0] trig_hyst;
  logic [AW-1:0] rd_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] dout;
  logic busy;
  logic frame_ready;
  logic frame_valid;
  logic trig_auto;
  logic [AW-1:0] trig_pos;
  modport master (
    output din, din_valid, arm, trig_mode, trig_ch, trig_level, trig_hyst, rd_addr,
    input dout, busy, frame_ready, frame_valid, trig_auto, trig_pos
  );
  modport slave (
    input din, din_valid, arm, trig_mode, trig_ch, trig_level, trig_hyst, rd_addr,
    output dout, busy, frame_ready, frame_valid, trig_auto, trig_pos
  );
endinterface

// File: rtl/trig_capture_sampler.sv
// trig_capture_sampler: pre/post-trigger circular capture of NUM_CH signed channels
module trig_capture_sampler #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_LEN = 1920,
  parameter int NUM_CH = 2,
  parameter int PRE_TRIG = 240,
  parameter int TIMEOUT = 65535
) (
  input logic clk,
  input logic rst_n,
  trig_capture_sampler_if.slave bus
);
  localparam int AW = $clog2(BUF_LEN);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int W = NUM_CH * DATA_WIDTH;
  localparam int XW = DATA_WIDTH + 2;
  localparam int POST_LEN = BUF_LEN - PRE_TRIG - 1;
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
  state_t state, nxt;
  logic [31:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic rise_armed, fall_armed;
  logic [W-1:0] mem [BUF_LEN];
  logic [CW-1:0] sel;
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [XW-1:0] xe, lvl, hyst, lo, hi;
  logic rise_fire, fall_fire, edge_fire, auto_fire, fire, we;
  logic [AW-1:0] base, phys;
  logic [AW:0] sum;
  assign sel = (32'(bus.trig_ch) >= NUM_CH) ? '0 : bus.trig_ch;
  assign x = bus.din[sel*DATA_WIDTH +: DATA_WIDTH];
  assign xe = XW'(x);
  assign lvl = XW'(signed'(bus.trig_level));
  assign hyst = signed'(XW'(bus.trig_hyst));
  assign lo = lvl - hyst;
  assign hi = lvl + hyst;
  // Flags remember a hysteresis-band excursion; the edge fires on the return to level
  assign rise_fire = rise_armed && xe >= lvl;
  assign fall_fire = fall_armed && xe <= lvl;
  assign edge_fire = (bus.trig_mode == 2'b11) ? 1'b1 :
                     (bus.trig_mode == 2'b10) ? (rise_fire || fall_fire) :
                     (bus.trig_mode == 2'b01) ? fall_fire : rise_fire;
  assign auto_fire = TIMEOUT != 0 && cnt + 32'd1 == 32'(TIMEOUT);
  assign fire = state == ARMED && bus.din_valid && (edge_fire || auto_fire);
  assign we = bus.din_valid && !bus.arm &&
              ((state == PRE && PRE_TRIG != 0) || state == ARMED || state == POST);
  always_comb begin
    nxt = state;
    nxt = bus.arm ? PRE :
          (state == PRE && (PRE_TRIG == 0 || (bus.din_valid && cnt + 32'd1 == 32'(PRE_TRIG)))) ? ARMED :
          fire ? ((POST_LEN == 0) ? DONE : POST) :
          (state == POST && bus.din_valid && cnt + 32'd1 == 32'(POST_LEN)) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      wr_ptr <= '0;
      rise_armed <= 1'b0;
      fall_armed <= 1'b0;
      bus.frame_ready <= 1'b0;
      bus.trig_auto <= 1'b0;
      bus.trig_pos <= '0;
    end else begin
      bus.frame_ready <= nxt == DONE && state != DONE;
      if (we) wr_ptr <= (32'(wr_ptr) == BUF_LEN - 1) ? '0 : wr_ptr + 1'b1;
      if (bus.arm || nxt != state) cnt <= '0;
      else if (we) cnt <= cnt + 32'd1;
      if (state != ARMED) begin
        rise_armed <= 1'b0;
        fall_armed <= 1'b0;
      end else if (bus.din_valid) begin
        rise_armed <= rise_armed || xe < lo;
        fall_armed <= fall_armed || xe > hi;
      end
      if (fire && !bus.arm) begin
        bus.trig_pos <= wr_ptr;
        bus.trig_auto <= !edge_fire;
      end
    end
  end
  assign bus.busy = state == PRE || state == ARMED || state == POST;
  assign bus.frame_valid = state == DONE;
  // Frame-relative read: oldest sample sits PRE_TRIG slots before the trigger, modulo BUF_LEN
  assign base = (32'(bus.trig_pos) >= PRE_TRIG) ? AW'(32'(bus.trig_pos) - PRE_TRIG)
                                                : AW'(32'(bus.trig_pos) + BUF_LEN - PRE_TRIG);
  assign sum = {1'b0, base} + {1'b0, bus.rd_addr};
  assign phys = (32'(sum) >= BUF_LEN) ? AW'(32'(sum) - BUF_LEN) : sum[AW-1:0];
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= bus.din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.dout <= '0;
    else bus.dout <= (32'(bus.rd_addr) >= BUF_LEN) ? '0 : mem[phys];
endmodule

// File: tb/tb_trig_capture_sampler.sv
// tb_trig_capture_sampler: directed scenarios on a 16-deep, 4-pretrigger, timeout-10 sampler
module tb_trig_capture_sampler;
  localparam int DW = 16;
  localparam int BL = 16;
  localparam int NC = 2;
  localparam int PT = 4;
  localparam int TO = 10;
  localparam int AW = $clog2(BL);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int fr_cnt = 0;
  int c0, c1;
  trig_capture_sampler_if #(.DATA_WIDTH(DW), .BUF_LEN(BL), .NUM_CH(NC)) bus ();
  trig_capture_sampler #(
    .DATA_WIDTH(DW), .BUF_LEN(BL), .NUM_CH(NC), .PRE_TRIG(PT), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.frame_ready) fr_cnt <= fr_cnt + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input int a, input int b);
    bus.din = {DW'(b), DW'(a)};
    bus.din_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_arm();
    bus.arm = 1'b1;
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.arm = 1'b0;
  endtask
  task automatic rd(input int a, output int r0, output int r1);
    logic signed [DW-1:0] t0, t1;
    bus.din_valid = 1'b0;
    bus.rd_addr = AW'(a);
    @(posedge clk);
    #1;
    t0 = bus.dout[DW-1:0];
    t1 = bus.dout[2*DW-1:DW];
    r0 = t0;
    r1 = t1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.arm = 1'b0;
    bus.trig_mode = 2'b00;
    bus.trig_ch = '0;
    bus.trig_level = '0;
    bus.trig_hyst = DW'(2);
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_frame_valid", int'(bus.frame_valid), 0);
    chk("rst_frame_ready", int'(bus.frame_ready), 0);
    chk("rst_trig_auto", int'(bus.trig_auto), 0);
    chk("rst_trig_pos", int'(bus.trig_pos), 0);
    chk("rst_dout", int'(bus.dout), 0);
    rst_n = 1'b1;
    repeat (3) step(1'b1, 55, 55);
    chk("idle_until_arm", int'(bus.busy), 0);
    // Ramp -8..+7, rising through 0 with hysteresis 2
    pulse_arm();
    chk("s1_busy", int'(bus.busy), 1);
    chk("s1_fv_low", int'(bus.frame_valid), 0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, -8 + (k % 16), -8 + (k % 16) + 1000);
      if (k == 18) chk("s1_not_done_early", int'(bus.frame_valid), 0);
    end
    chk("s1_frame_valid", int'(bus.frame_valid), 1);
    chk("s1_frame_ready", int'(bus.frame_ready), 1);
    chk("s1_trig_pos", int'(bus.trig_pos), 8);
    chk("s1_trig_auto", int'(bus.trig_auto), 0);
    step(1'b0, 0, 0);
    chk("s1_ready_one_cycle", int'(bus.frame_ready), 0);
    chk("s1_valid_held", int'(bus.frame_valid), 1);
    rd(4, c0, c1);
    chk("s1_rd4", c0, 0);
    rd(0, c0, c1);
    chk("s1_rd0", c0, -4);
    chk("s1_rd0_ch1", c1, 996);
    rd(12, c0, c1);
    chk("s1_rd12", c0, -8);
    rd(15, c0, c1);
    chk("s1_rd15", c0, -5);
    // Constant 100 never crosses upward: auto-trigger on 10th valid ARMED sample, with gaps
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 100, 100);
      step(1'b0, 100, 100);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 100, 100);
      if (i == 8) chk("s2_no_early_auto", int'(bus.trig_pos), 8);
      step(1'b0, 100, 100);
    end
    chk("s2_trig_pos", int'(bus.trig_pos), 1);
    chk("s2_trig_auto", int'(bus.trig_auto), 1);
    chk("s2_busy", int'(bus.busy), 1);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 100, 100);
      if (i == 9) chk("s2_gap_no_count", int'(bus.frame_valid), 0);
      step(1'b0, 100, 100);
    end
    chk("s2_frame_valid", int'(bus.frame_valid), 1);
    rd(0, c0, c1);
    chk("s2_rd0", c0, 100);
    chk("s2_rd0_ch1", c1, 100);
    // Asynchronous reset in the middle of ARMED
    pulse_arm();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 50, 50);
      step(1'b0, 50, 50);
    end
    chk("s5_busy_pre_rst", int'(bus.busy), 1);
    bus.din_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("s5_busy", int'(bus.busy), 0);
    chk("s5_frame_valid", int'(bus.frame_valid), 0);
    chk("s5_frame_ready", int'(bus.frame_ready), 0);
    chk("s5_trig_auto", int'(bus.trig_auto), 0);
    chk("s5_trig_pos", int'(bus.trig_pos), 0);
    chk("s5_dout", int'(bus.dout), 0);
    for (int i = 0; i < 4; i++) step(1'(i % 2), 50, 50);
    rst_n = 1'b1;
    repeat (3) step(1'b1, 50, 50);
    chk("s5_idle_after_rst", int'(bus.busy), 0);
    // Hover within hysteresis band, then a real swing
    bus.trig_hyst = DW'(4);
    pulse_arm();
    repeat (4) step(1'b1, 0, 0);
    step(1'b1, 1, 0);
    step(1'b1, -1, 0);
    step(1'b1, 1, 0);
    step(1'b1, -1, 0);
    chk("s3_hover_no_trig", int'(bus.trig_pos), 0);
    chk("s3_hover_busy", int'(bus.busy), 1);
    step(1'b1, -10, 0);
    chk("s3_low_no_trig", int'(bus.trig_pos), 0);
    step(1'b1, 10, 0);
    chk("s3_trig_pos", int'(bus.trig_pos), 9);
    chk("s3_trig_auto", int'(bus.trig_auto), 0);
    repeat (11) step(1'b1, 7, 0);
    chk("s3_frame_valid", int'(bus.frame_valid), 1);
    rd(3, c0, c1);
    chk("s3_rd3", c0, -10);
    rd(4, c0, c1);
    chk("s3_rd4", c0, 10);
    rd(0, c0, c1);
    chk("s3_rd0", c0, -1);
    // Free-run, re-arm in POST, trigger lands on wrapped address 0
    bus.trig_mode = 2'b11;
    pulse_arm();
    repeat (4) step(1'b1, 50, 0);
    step(1'b1, 51, 0);
    chk("s4_freerun_pos", int'(bus.trig_pos), 9);
    repeat (2) step(1'b1, 52, 0);
    chk("s4_busy_post", int'(bus.busy), 1);
    pulse_arm();
    chk("s4_rearm_busy", int'(bus.busy), 1);
    chk("s4_rearm_fv", int'(bus.frame_valid), 0);
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 300 + j, 0);
      if (j == 3) chk("s4_pre_restart", int'(bus.trig_pos), 9);
      if (j == 4) chk("s4_trig_pos_wrap", int'(bus.trig_pos), 0);
      if (j == 14) chk("s4_not_done_early", int'(bus.frame_valid), 0);
    end
    chk("s4_frame_valid", int'(bus.frame_valid), 1);
    rd(0, c0, c1);
    chk("s4_rd0", c0, 300);
    rd(15, c0, c1);
    chk("s4_rd15", c0, 315);
    rd(4, c0, c1);
    chk("s4_rd4", c0, 304);
    step(1'b0, 0, 0);
    chk("frame_ready_pulses", fr_cnt, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trig_capture_sampler.md
TRIG_CAPTURE_SAMPLER -- requirements
Module: trig_capture_sampler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width per channel, signed.
REQ-002 SHALL have parameter BUF_LEN, default 1920: samples per channel per frame.
REQ-003 SHALL have parameter NUM_CH, default 2: number of channels; AW=$clog2(BUF_LEN), CW=max(1,$clog2(NUM_CH)).
REQ-004 SHALL have parameter PRE_TRIG, default 240: samples kept before the trigger sample; legal range 0..BUF_LEN-1.
REQ-005 SHALL have parameter TIMEOUT, default 65535: valid samples in ARMED before auto-trigger; 0 disables auto-trigger.
REQ-006 SHALL have port clk, input, 1: sole clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port din, input, NUM_CH*DATA_WIDTH: packed signed samples, ch0 in LSBs.
REQ-009 SHALL have port din_valid, input, 1: din qualifier.
REQ-010 SHALL have port arm, input, 1: single-cycle request to start a capture.
REQ-011 SHALL have port trig_mode, input, 2: 00 rising, 01 falling, 10 either edge, 11 free-run.
REQ-012 SHALL have port trig_ch, input, CW: trigger source channel; values >= NUM_CH select ch0.
REQ-013 SHALL have port trig_level, input, DATA_WIDTH: signed threshold.
REQ-014 SHALL have port trig_hyst, input, DATA_WIDTH: unsigned hysteresis.
REQ-015 SHALL have port rd_addr, input, AW: frame-relative read address (0 = oldest sample).
REQ-016 SHALL have port dout, output, NUM_CH*DATA_WIDTH: all channels at rd_addr.
REQ-017 SHALL have port busy, output, 1: high in PRE, ARMED, POST.
REQ-018 SHALL have port frame_ready, output, 1: one-cycle pulse on frame completion.
REQ-019 SHALL have port frame_valid, output, 1: high in DONE.
REQ-020 SHALL have port trig_auto, output, 1: last frame was auto-triggered (timeout).
REQ-021 SHALL have port trig_pos, output, AW: physical buffer address of the trigger sample.

Function
REQ-022 SHALL implement states IDLE, PRE, ARMED, POST, DONE; arm in any state clears the write count and enters PRE next cycle, dropping frame_valid.
REQ-023 SHALL, in PRE/ARMED/POST, write din into a circular buffer at wr_ptr on each din_valid, wr_ptr wrapping BUF_LEN-1 -> 0; no writes in IDLE/DONE.
REQ-024 SHALL leave PRE for ARMED once PRE_TRIG samples are written (immediately when PRE_TRIG=0).
REQ-025 SHALL evaluate the edge on the trig_ch sample in ARMED only, arithmetic in DATA_WIDTH+2 signed: rising arms when x < level-hyst, fires when armed and x >= level; falling arms when x > level+hyst, fires when armed and x <= level; either = rising OR falling; free-run fires on the first ARMED sample.
REQ-026 SHALL clear the edge-armed flags on entry to ARMED, so a sample already beyond threshold never fires without first crossing the hysteresis band.
REQ-027 SHALL auto-trigger on the TIMEOUT-th valid ARMED sample when no edge fired; edge fire on that same sample wins and trig_auto = 0.
REQ-028 SHALL write the trigger sample, latch its address into trig_pos, and go to POST; POST ends after BUF_LEN-PRE_TRIG-1 more samples (0 -> straight to DONE).
REQ-029 SHALL pulse frame_ready for exactly one cycle on entry to DONE; frame_valid stays high until next arm.
REQ-030 SHALL map reads as phys = (trig_pos - PRE_TRIG + rd_addr) mod BUF_LEN, without overflow beyond AW+1 bits; dout registered, latency 1 cycle; rd_addr >= BUF_LEN -> dout 0.
REQ-031 SHALL allow reads in any state; content is guaranteed only while frame_valid = 1.
REQ-032 SHALL infer the buffer as inference-friendly block RAM (one write port, one registered read port).

Reset
REQ-033 SHALL, on rst_n low, asynchronously force IDLE, wr_ptr=0, counters=0, edge flags=0, busy=0, frame_ready=0, frame_valid=0, trig_auto=0, trig_pos=0, dout=0; RAM contents not reset.
REQ-034 SHALL, after rst_n release, stay in IDLE until arm.

Verification
REQ-035 SHALL cover: BUF_LEN=16, PRE_TRIG=4, ramp -8..+7 on ch0 repeating, level 0, hyst 2, rising, arm -> trigger at first 0 after -3 seen; rd_addr 4 returns 0, rd_addr 0 returns -4, frame_ready one pulse.
REQ-036 SHALL cover: constant din=100, level 0, TIMEOUT=10 -> frame completes with trig_auto=1 after PRE_TRIG+10 valid samples in ARMED sequence.
REQ-037 SHALL cover: din hovering +/-1 around level, hyst 4 -> no edge trigger; then swing to -10 then +10 -> one trigger at first sample >= level.
REQ-038 SHALL cover: arm asserted mid-POST -> busy stays high, frame_valid low, new frame starts PRE count from 0; trig_pos wraps correctly across BUF_LEN-1 -> 0.
REQ-039 SHALL cover: rst_n low mid-ARMED with din_valid toggling -> all outputs 0 within same cycle, no further writes; din_valid gaps never advance counters.
